if_fetch_stage: RTL and testbench



---
 rtl/if_fetch_stage.sv | 80 ++++++++
 tb/tb_if_fetch_stage.sv | 126 ++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC register and fetch control for a variable-latency instruction memory.
// Define IF_FETCH_PERF_EN to add the perf_fetch_cnt / perf_wait_cnt counters.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        freeze,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] PC_Out,
    output logic [31:0] Instruction_Out,
    output logic        Inst_Valid,
    output logic        fetch_stall
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_wait_cnt
`endif
);
    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;
    state_t state, state_n;
    logic [31:0] pc, pc_n, pc_inc, req_addr, inst_buf, inst_buf_n;
    assign pc_inc = pc + 32'd4;
    assign PC_Out = pc_inc;
    assign imem_req = state != HOLD;
    assign imem_addr = state == DISCARD ? req_addr : pc;
    assign Inst_Valid = state == HOLD ? 1'b1 : state == FETCH ? imem_ack : 1'b0;
    assign Instruction_Out = state == HOLD ? inst_buf : (state == FETCH && imem_ack) ? imem_rdata : NOP_INST;
    assign fetch_stall = ~Inst_Valid;
    // A redirect wins over everything; an unacked fetch must still be drained in DISCARD.
    always_comb begin
        state_n = state;
        pc_n = pc;
        inst_buf_n = inst_buf;
        if (Branch_Taken) begin
            pc_n = Branch_Addr & ~32'd3;
            inst_buf_n = NOP_INST;
            state_n = (state == HOLD || imem_ack) ? FETCH : DISCARD;
        end else if (state == FETCH && imem_ack) begin
            state_n = freeze ? HOLD : FETCH;
            pc_n = freeze ? pc : pc_inc;
            inst_buf_n = freeze ? imem_rdata : inst_buf;
        end else if (state == HOLD && !freeze) begin
            state_n = FETCH;
            pc_n = pc_inc;
        end else if (state == DISCARD && imem_ack) begin
            state_n = FETCH;
        end
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= FETCH;
            pc <= RESET_PC & ~32'd3;
            req_addr <= RESET_PC & ~32'd3;
            inst_buf <= NOP_INST;
        end else begin
            state <= state_n;
            pc <= pc_n;
            inst_buf <= inst_buf_n;
            if (state == FETCH) req_addr <= pc;
        end
    end
`ifdef IF_FETCH_PERF_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_fetch_cnt <= 32'd0;
            perf_wait_cnt <= 32'd0;
        end else begin
            if (Inst_Valid && !freeze && !Branch_Taken) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (imem_req && !imem_ack) perf_wait_cnt <= perf_wait_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed and random fetch scenarios against a behavioural model of the fetch stage.
module tb_if_fetch_stage;
    logic CLK = 0, RST = 1, freeze = 0, Branch_Taken = 0, imem_ack = 0;
    logic [31:0] Branch_Addr = 0, imem_rdata = 0;
    logic imem_req, Inst_Valid, fetch_stall;
    logic [31:0] imem_addr, PC_Out, Instruction_Out;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_wait_cnt;
`endif
    if_fetch_stage dut (
        .CLK(CLK), .RST(RST), .freeze(freeze), .Branch_Taken(Branch_Taken), .Branch_Addr(Branch_Addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .PC_Out(PC_Out), .Instruction_Out(Instruction_Out), .Inst_Valid(Inst_Valid), .fetch_stall(fetch_stall)
`ifdef IF_FETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_wait_cnt(perf_wait_cnt)
`endif
    );
    always #5 CLK = ~CLK;
    int n_chk = 0, n_fail = 0;
    // reference model: architectural pc, a held word, and an outstanding fetch to be thrown away
    logic [31:0] m_pc, m_buf, m_paddr, m_fc, m_wc;
    logic m_have, m_poison;
    // memory model
    logic busy;
    int cnt, lat_fix;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        m_pc = 0; m_buf = 0; m_paddr = 0; m_have = 0; m_poison = 0; m_fc = 0; m_wc = 0;
        busy = 0; cnt = 0;
    endtask
    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        chk({tag, "_addr"}, imem_addr, 32'd0);
        chk({tag, "_pcout"}, PC_Out, 32'd4);
        chk({tag, "_valid"}, {31'd0, Inst_Valid}, 32'd0);
        chk({tag, "_inst"}, Instruction_Out, 32'd0);
        chk({tag, "_stall"}, {31'd0, fetch_stall}, 32'd1);
    endtask
    task automatic step(input logic br, input logic [31:0] ba, input logic frz);
        logic ack, e_valid;
        logic [31:0] rd, e_inst;
        Branch_Taken = br; Branch_Addr = ba; freeze = frz;
        ack = 0; rd = $urandom;
        if (!busy && imem_req) begin
            busy = 1;
            cnt = (lat_fix > 0 ? lat_fix : int'($urandom_range(1, 4))) - 1;
        end
        if (busy && cnt == 0) begin ack = 1; busy = 0; end
        else if (busy) cnt--;
        imem_ack = ack; imem_rdata = rd;
        #1;
        e_valid = m_have || (!m_poison && ack);
        e_inst = m_have ? m_buf : e_valid ? rd : 32'd0;
        chk("req", {31'd0, imem_req}, {31'd0, !m_have});
        if (!m_have) chk("addr", imem_addr, m_poison ? m_paddr : m_pc);
        chk("pcout", PC_Out, m_pc + 32'd4);
        chk("valid", {31'd0, Inst_Valid}, {31'd0, e_valid});
        chk("stall", {31'd0, fetch_stall}, {31'd0, !e_valid});
        chk("inst", Instruction_Out, e_inst);
`ifdef IF_FETCH_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, m_fc);
        chk("perf_wait", perf_wait_cnt, m_wc);
        m_fc += {31'd0, e_valid && !frz && !br};
        m_wc += {31'd0, !m_have && !ack};
`endif
        if (br) begin
            if (m_have) m_have = 0;
            else if (!ack) begin
                if (!m_poison) m_paddr = m_pc;
                m_poison = 1;
            end else m_poison = 0;
            m_pc = ba & ~32'd3;
        end else if (m_have) begin
            if (!frz) begin m_have = 0; m_pc += 4; end
        end else if (ack) begin
            if (m_poison) m_poison = 0;
            else if (frz) begin m_have = 1; m_buf = rd; end
            else m_pc += 4;
        end
        @(negedge CLK);
    endtask
    initial begin
        model_reset();
        lat_fix = 1;
        #2 chk_reset_outputs("reset");
        @(negedge CLK);
        RST = 0;
        // zero-wait streaming 0,4,8,C
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        // 3-cycle fetch at 0x10
        lat_fix = 3;
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        // ack under freeze, hold, then resume
        lat_fix = 1;
        step(0, 0, 1); step(0, 0, 1); step(0, 0, 0); step(0, 0, 0);
        // redirect into a pending fetch of 0x20
        step(1, 32'h20, 0);
        lat_fix = 3;
        step(0, 0, 0); step(1, 32'h100, 0); step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
        // redirect from HOLD with freeze, then wrap at top of address space
        lat_fix = 1;
        step(0, 0, 1); step(1, 32'h100, 1); step(0, 0, 0);
        step(1, 32'hFFFF_FFFF, 0); step(0, 0, 0); step(0, 0, 0);
        // async reset while discarding
        lat_fix = 3;
        step(0, 0, 0); step(1, 32'h40, 0); step(0, 0, 0);
        imem_ack = 0; Branch_Taken = 0; freeze = 0;
        #2 RST = 1;
        #1 chk_reset_outputs("async_reset");
        @(negedge CLK);
        RST = 0;
        model_reset();
        // random traffic
        lat_fix = 0;
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 11) == 0, $urandom, $urandom_range(0, 3) == 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
